// File: rtl/sram_token_arbiter.sv
// Hands exclusive ownership of the external SRAM port to each enabled client in
// index order once per frame, with per-grant timeout and frame-overrun flagging.
module sram_token_arbiter #(
    parameter int N_CLIENTS = 3,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 63
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_frame_start,
    input  logic [N_CLIENTS-1:0]          i_client_en,
    input  logic [N_CLIENTS*ADDR_W-1:0]   i_req_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]   i_req_wdata,
    input  logic [N_CLIENTS-1:0]          i_req_we_n,
    input  logic [N_CLIENTS-1:0]          i_done,
    output logic [N_CLIENTS-1:0]          o_grant,
    output logic [ADDR_W-1:0]             o_sram_addr,
    output logic                          o_sram_we_n,
    output logic [DATA_W-1:0]             o_sram_wdata,
    output logic                          o_sram_drive,
    output logic                          o_busy,
    output logic                          o_round_done,
    output logic                          o_timeout,
    output logic                          o_overrun
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               round_done_q, round_done_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;

    logic               first_found, next_found;
    logic [IDX_W-1:0]   first_idx, next_idx;
    logic               cur_done, cur_en, expired, release_now;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int j = N_CLIENTS - 1; j >= 0; j--) begin
            if (i_client_en[j]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(j);
                if (j > int'(owner_q)) begin
                    next_found = 1'b1;
                    next_idx   = IDX_W'(j);
                end
            end
        end
    end

    always_comb begin
        cur_done = 1'b0;
        cur_en   = 1'b0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (owner_q == IDX_W'(k)) begin
                cur_done = i_done[k];
                cur_en   = i_client_en[k];
            end
        end
        expired     = (cnt_q == 8'(TIMEOUT - 1));
        release_now = cur_done | expired | ~cur_en;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        round_done_d = 1'b0;
        timeout_d    = 1'b0;
        overrun_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_frame_start) begin
                    if (first_found) begin
                        state_d = S_GRANT;
                        owner_d = first_idx;
                        cnt_d   = '0;
                    end else begin
                        round_done_d = 1'b1;
                    end
                end
            end
            S_GRANT: begin
                overrun_d = i_frame_start;
                cnt_d     = cnt_q + 8'd1;
                if (release_now) begin
                    // Timeout is reported only when nothing else ended the grant.
                    timeout_d = expired & ~cur_done & cur_en;
                    cnt_d     = '0;
                    if (next_found) begin
                        owner_d = next_idx;
                    end else begin
                        state_d      = S_IDLE;
                        owner_d      = '0;
                        round_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            cnt_q        <= '0;
            round_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            round_done_q <= round_done_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        o_grant      = '0;
        o_sram_addr  = '0;
        o_sram_we_n  = 1'b1;
        o_sram_wdata = '0;
        o_sram_drive = 1'b0;
        if (state_q == S_GRANT) begin
            for (int k = 0; k < N_CLIENTS; k++) begin
                if (owner_q == IDX_W'(k)) begin
                    o_grant[k]   = 1'b1;
                    o_sram_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
                    o_sram_we_n  = i_req_we_n[k];
                    o_sram_drive = ~i_req_we_n[k];
                    o_sram_wdata = i_req_we_n[k] ? '0 : i_req_wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign o_busy       = (state_q == S_GRANT);
    assign o_round_done = round_done_q;
    assign o_timeout    = timeout_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_sram_token_arbiter.sv
// Bench for sram_token_arbiter: directed rounds plus random traffic, every cycle
// compared against a cycle-level ownership model built from the arbitration rules.
module tb_sram_token_arbiter;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int TO = 6;

    logic            clk = 1'b0;
    logic            i_rst, i_frame_start;
    logic [N-1:0]    i_client_en, i_req_we_n, i_done;
    logic [N*AW-1:0] i_req_addr;
    logic [N*DW-1:0] i_req_wdata;
    logic [N-1:0]    o_grant;
    logic [AW-1:0]   o_sram_addr;
    logic            o_sram_we_n, o_sram_drive, o_busy, o_round_done, o_timeout, o_overrun;
    logic [DW-1:0]   o_sram_wdata;

    always #5 clk = ~clk;

    sram_token_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
        .i_client_en(i_client_en), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_we_n(i_req_we_n), .i_done(i_done), .o_grant(o_grant),
        .o_sram_addr(o_sram_addr), .o_sram_we_n(o_sram_we_n), .o_sram_wdata(o_sram_wdata),
        .o_sram_drive(o_sram_drive), .o_busy(o_busy), .o_round_done(o_round_done),
        .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    int checks = 0, errors = 0;
    int m_owner = -1, m_held = 0;          // -1 = nobody owns the SRAM
    bit m_rd = 0, m_to = 0, m_ov = 0;       // pulses expected this cycle
    bit chk_on = 0;
    int dly[N];                             // grant cycle index on which owner raises done
    int g_cnt[N];
    int rd_cnt, to_cnt, ov_cnt, busy_cnt, guard;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_en_from(input int k);
        for (int j = k; j < N; j++) if (i_client_en[j]) return j;
        return -1;
    endfunction

    task automatic clear_obs();
        for (int k = 0; k < N; k++) g_cnt[k] = 0;
        rd_cnt = 0; to_cnt = 0; ov_cnt = 0; busy_cnt = 0;
    endtask

    task automatic set_done();
        i_done = '0;
        if (m_owner >= 0 && m_held == dly[m_owner]) i_done[m_owner] = 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] edat;
        logic          ew, ed;
        int n_owner, n_held, nxt;
        bit n_rd, n_to, n_ov, expired;
        @(negedge clk);
        eg = '0; ea = '0; ew = 1'b1; ed = 1'b0; edat = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ea   = i_req_addr[m_owner*AW +: AW];
            ew   = i_req_we_n[m_owner];
            ed   = ~ew;
            edat = ed ? i_req_wdata[m_owner*DW +: DW] : '0;
        end
        if (chk_on) begin
            chk("grant", o_grant, eg);
            chk("addr", o_sram_addr, ea);
            chk("we_n", o_sram_we_n, ew);
            chk("drive", o_sram_drive, ed);
            chk("wdata", o_sram_wdata, edat);
            chk("busy", o_busy, m_owner >= 0);
            chk("round_done", o_round_done, m_rd);
            chk("timeout", o_timeout, m_to);
            chk("overrun", o_overrun, m_ov);
        end
        for (int k = 0; k < N; k++) g_cnt[k] += int'(o_grant[k]);
        rd_cnt += int'(o_round_done); to_cnt += int'(o_timeout);
        ov_cnt += int'(o_overrun);    busy_cnt += int'(o_busy);
        n_owner = m_owner; n_held = m_held; n_rd = 0; n_to = 0; n_ov = 0;
        if (i_rst) begin
            n_owner = -1; n_held = 0;
        end else if (m_owner < 0) begin
            if (i_frame_start) begin
                nxt = lowest_en_from(0);
                if (nxt >= 0) begin n_owner = nxt; n_held = 0; end
                else n_rd = 1;
            end
        end else begin
            n_ov    = i_frame_start;
            expired = (m_held == TO - 1);
            if (i_done[m_owner] || expired || !i_client_en[m_owner]) begin
                n_to = expired && !i_done[m_owner] && i_client_en[m_owner];
                nxt  = lowest_en_from(m_owner + 1);
                n_held = 0;
                if (nxt >= 0) n_owner = nxt;
                else begin n_owner = -1; n_rd = 1; end
            end else begin
                n_held = m_held + 1;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_held = n_held; m_rd = n_rd; m_to = n_to; m_ov = n_ov;
    endtask

    task automatic run(input int n);
        repeat (n) begin set_done(); tick(); end
    endtask

    task automatic pulse_fs();
        i_frame_start = 1'b1; set_done(); tick(); i_frame_start = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_frame_start = 1'b0; i_client_en = '0; i_req_we_n = '1;
        i_done = '0; i_req_wdata = '0;
        i_req_addr = {20'hFFFFF, 20'h40000, 20'h00010};
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1;
        tick();                              // reset still asserted: reset outputs checked
        i_rst = 1'b0;

        // Full round with three enabled clients
        i_client_en = 3'b111; dly = '{2, 3, 4};
        clear_obs(); pulse_fs(); run(20);
        chk("t1_g0", g_cnt[0], 3); chk("t1_g1", g_cnt[1], 4); chk("t1_g2", g_cnt[2], 5);
        chk("t1_rd", rd_cnt, 1);

        // Skip a disabled client, then an empty round
        i_client_en = 3'b101; dly = '{0, 0, 2};
        clear_obs(); pulse_fs(); run(10);
        chk("t2_g0", g_cnt[0], 1); chk("t2_g1", g_cnt[1], 0); chk("t2_g2", g_cnt[2], 3);
        i_client_en = 3'b000;
        clear_obs(); pulse_fs();
        chk("t2_rd_next", o_round_done, 1'b1);
        run(3);
        chk("t2_busy", busy_cnt, 0); chk("t2_rd", rd_cnt, 1);

        // Timeout on client 1, then done coinciding with timeout
        i_client_en = 3'b111; dly = '{0, 255, 0};
        clear_obs(); pulse_fs(); run(15);
        chk("t3_g1", g_cnt[1], TO); chk("t3_to", to_cnt, 1); chk("t3_g2", g_cnt[2], 1);
        dly[1] = TO - 1;
        clear_obs(); pulse_fs(); run(15);
        chk("t3b_g1", g_cnt[1], TO); chk("t3b_to", to_cnt, 0);

        // Write then read by client 0
        i_client_en = 3'b001; i_req_we_n = 3'b110; i_req_wdata = {16'h1111, 16'h2222, 16'hA5A5};
        dly = '{255, 0, 0};
        pulse_fs();
        chk("t4_drive_w", o_sram_drive, 1'b1); chk("t4_wdata_w", o_sram_wdata, 16'hA5A5);
        i_req_we_n = 3'b111;
        #1;
        chk("t4_drive_r", o_sram_drive, 1'b0); chk("t4_wdata_r", o_sram_wdata, 16'h0000);
        dly[0] = 0; run(4);

        // Overrun mid-round, then on the cycle of the last done
        i_client_en = 3'b111; dly = '{1, 4, 1};
        clear_obs(); pulse_fs();
        guard = 0;
        while (m_owner != 1 && guard < 50) begin set_done(); tick(); guard++; end
        chk("t5_reach1", m_owner, 1);
        pulse_fs(); run(15);
        chk("t5_ov", ov_cnt, 1); chk("t5_g0", g_cnt[0], 2); chk("t5_g1", g_cnt[1], 5);
        chk("t5_g2", g_cnt[2], 2); chk("t5_rd", rd_cnt, 1);
        clear_obs(); pulse_fs();
        guard = 0;
        while (!(m_owner == 2 && m_held == dly[2]) && guard < 50) begin set_done(); tick(); guard++; end
        chk("t5_reach2", m_owner, 2);
        pulse_fs();
        chk("t5_ov_last", o_overrun, 1'b1); chk("t5_busy_last", o_busy, 1'b0);
        run(5);
        chk("t5_ov2", ov_cnt, 1); chk("t5_g0b", g_cnt[0], 2); chk("t5_busy_end", o_busy, 1'b0);

        // Reset during client 1's grant
        dly = '{1, 255, 1};
        pulse_fs();
        guard = 0;
        while (m_owner != 1 && guard < 50) begin set_done(); tick(); guard++; end
        run(1);
        i_rst = 1'b1; set_done(); tick(); i_rst = 1'b0;
        chk("t6_grant", o_grant, 3'b000); chk("t6_we_n", o_sram_we_n, 1'b1);
        chk("t6_drive", o_sram_drive, 1'b0); chk("t6_busy", o_busy, 1'b0);
        pulse_fs();
        chk("t6_regrant", o_grant, 3'b001);
        dly[1] = 0; run(10);

        // Random traffic
        repeat (600) begin
            i_rst         = ($urandom_range(0, 99) == 0);
            i_frame_start = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) i_client_en = N'($urandom);
            i_req_we_n  = N'($urandom);
            i_req_addr  = {AW'($urandom), AW'($urandom), AW'($urandom)};
            i_req_wdata = {DW'($urandom), DW'($urandom), DW'($urandom)};
            i_done      = N'($urandom) & N'($urandom);
            tick();
        end
        i_rst = 1'b0; i_frame_start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
